// File: rtl/cursor_draw_ctrl.sv
// rtl/cursor_draw_ctrl.sv - tick-paced cursor mover with brush plotter; CURSOR_CLEAR_EN builds the clear sweep
module cursor_draw_ctrl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int COLOUR_W = 3,
    parameter int BRUSH    = 2,
    parameter int TICK_DIV = 5000000,
    parameter int WRAP     = 0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [3:0]          dir_n,
    input  logic                pen_down,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [X_W-1:0]      cur_x,
    output logic [Y_W-1:0]      cur_y,
    output logic                busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int B_W   = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
`ifdef CURSOR_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd2;
`endif

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [X_W-1:0]      cur_x_q, cur_x_d;
    logic [Y_W-1:0]      cur_y_q, cur_y_d;
    logic [B_W-1:0]      bx_q, bx_d;
    logic [B_W-1:0]      by_q, by_d;
    logic [COLOUR_W-1:0] col_lat_q, col_lat_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
`ifdef CURSOR_CLEAR_EN
    logic [X_W-1:0]      sx_q, sx_d;
    logic [Y_W-1:0]      sy_q, sy_d;
`else
    logic                unused_clear;
    assign unused_clear = clear_req;
`endif

    logic           tick;
    logic           mv_r, mv_l, mv_d, mv_u;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic [X_W+1:0] px;
    logic [Y_W+1:0] py;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Opposing keys on one axis cancel; the two axes are independent.
    assign mv_r = ~dir_n[0] & dir_n[3];
    assign mv_l = ~dir_n[3] & dir_n[0];
    assign mv_d = ~dir_n[1] & dir_n[2];
    assign mv_u = ~dir_n[2] & dir_n[1];

    always_comb begin
        nx = cur_x_q;
        if (mv_r) begin
            if (cur_x_q == X_W'(X_MAX)) nx = (WRAP != 0) ? '0 : cur_x_q;
            else                         nx = cur_x_q + 1'b1;
        end else if (mv_l) begin
            if (cur_x_q == '0) nx = (WRAP != 0) ? X_W'(X_MAX) : '0;
            else               nx = cur_x_q - 1'b1;
        end
        ny = cur_y_q;
        if (mv_d) begin
            if (cur_y_q == Y_W'(Y_MAX)) ny = (WRAP != 0) ? '0 : cur_y_q;
            else                         ny = cur_y_q + 1'b1;
        end else if (mv_u) begin
            if (cur_y_q == '0) ny = (WRAP != 0) ? Y_W'(Y_MAX) : '0;
            else               ny = cur_y_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        bx_d      = bx_q;
        by_d      = by_q;
        col_lat_d = col_lat_q;
`ifdef CURSOR_CLEAR_EN
        sx_d      = sx_q;
        sy_d      = sy_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CURSOR_CLEAR_EN
                if (clear_req) begin
                    state_d = S_CLEAR;
                    sx_d    = '0;
                    sy_d    = '0;
                    pend_d  = pend_q | tick;
                end else
`endif
                if (tick || pend_q) begin
                    cur_x_d = nx;
                    cur_y_d = ny;
                    pend_d  = 1'b0;
                    bx_d    = '0;
                    by_d    = '0;
                    if (pen_down) begin
                        state_d   = S_DRAW;
                        col_lat_d = colour_in;
                    end
                end
            end
            S_DRAW: begin
                if (tick) pend_d = 1'b1;
                if (bx_q == B_W'(BRUSH - 1)) begin
                    bx_d = '0;
                    if (by_q == B_W'(BRUSH - 1)) state_d = S_IDLE;
                    else                         by_d = by_q + 1'b1;
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
`ifdef CURSOR_CLEAR_EN
            S_CLEAR: begin
                if (tick) pend_d = 1'b1;
                if (sx_q == X_W'(X_MAX)) begin
                    sx_d = '0;
                    if (sy_q == Y_W'(Y_MAX)) state_d = S_IDLE;
                    else                     sy_d = sy_q + 1'b1;
                end else begin
                    sx_d = sx_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel outputs are built from next-state values so the registered
    // pixel lines up with the DRAW/CLEAR cycle it belongs to.
    assign px = {2'b00, cur_x_d} + (X_W + 2)'(bx_d);
    assign py = {2'b00, cur_y_d} + (Y_W + 2)'(by_d);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (state_d == S_DRAW) begin
            x_d      = px[X_W-1:0];
            y_d      = py[Y_W-1:0];
            colour_d = col_lat_d;
            plot_d   = (px <= (X_W + 2)'(X_MAX)) && (py <= (Y_W + 2)'(Y_MAX));
        end
`ifdef CURSOR_CLEAR_EN
        else if (state_d == S_CLEAR) begin
            x_d      = sx_d;
            y_d      = sy_d;
            colour_d = '0;
            plot_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            col_lat_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
`ifdef CURSOR_CLEAR_EN
            sx_q      <= '0;
            sy_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            col_lat_q <= col_lat_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
`ifdef CURSOR_CLEAR_EN
            sx_q      <= sx_d;
            sy_q      <= sy_d;
`endif
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign cur_x  = cur_x_q;
    assign cur_y  = cur_y_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_cursor_draw_ctrl.sv
// tb/tb_cursor_draw_ctrl.sv - directed bench for cursor_draw_ctrl over four parameter sets
module tb_cursor_draw_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dn  [4];
    logic       pd  [4];
    logic       cl  [4];
    logic [2:0] ci  [4];
    logic [7:0] xo  [4];
    logic [6:0] yo  [4];
    logic [2:0] co  [4];
    logic       pl  [4];
    logic [7:0] cx  [4];
    logic [6:0] cy  [4];
    logic       bz  [4];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // u0: clamp, brush 2; u1: wrap; u2: brush 4 fast tick; u3: tiny screen for clear
    cursor_draw_ctrl #(.TICK_DIV(4), .WRAP(0), .BRUSH(2)) u0 (
        .CLOCK_50(clk), .reset(rst), .dir_n(dn[0]), .pen_down(pd[0]), .clear_req(cl[0]),
        .colour_in(ci[0]), .x(xo[0]), .y(yo[0]), .colour(co[0]), .plot(pl[0]),
        .cur_x(cx[0]), .cur_y(cy[0]), .busy(bz[0]));
    cursor_draw_ctrl #(.TICK_DIV(4), .WRAP(1), .BRUSH(2)) u1 (
        .CLOCK_50(clk), .reset(rst), .dir_n(dn[1]), .pen_down(pd[1]), .clear_req(cl[1]),
        .colour_in(ci[1]), .x(xo[1]), .y(yo[1]), .colour(co[1]), .plot(pl[1]),
        .cur_x(cx[1]), .cur_y(cy[1]), .busy(bz[1]));
    cursor_draw_ctrl #(.TICK_DIV(2), .WRAP(0), .BRUSH(4)) u2 (
        .CLOCK_50(clk), .reset(rst), .dir_n(dn[2]), .pen_down(pd[2]), .clear_req(cl[2]),
        .colour_in(ci[2]), .x(xo[2]), .y(yo[2]), .colour(co[2]), .plot(pl[2]),
        .cur_x(cx[2]), .cur_y(cy[2]), .busy(bz[2]));
    cursor_draw_ctrl #(.TICK_DIV(4), .X_MAX(3), .Y_MAX(1)) u3 (
        .CLOCK_50(clk), .reset(rst), .dir_n(dn[3]), .pen_down(pd[3]), .clear_req(cl[3]),
        .colour_in(ci[3]), .x(xo[3]), .y(yo[3]), .colour(co[3]), .plot(pl[3]),
        .cur_x(cx[3]), .cur_y(cy[3]), .busy(bz[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_x_ne(input int i, input logic [7:0] old, input int budget);
        for (int k = 0; k < budget && cx[i] == old; k++) @(negedge clk);
        chk("x_move_seen", 32'(cx[i] != old), 1);
    endtask

    task automatic wait_y_ne(input int i, input logic [6:0] old, input int budget);
        for (int k = 0; k < budget && cy[i] == old; k++) @(negedge clk);
        chk("y_move_seen", 32'(cy[i] != old), 1);
    endtask

    task automatic wait_x_eq(input int i, input logic [7:0] val, input int budget);
        for (int k = 0; k < budget && cx[i] != val; k++) @(negedge clk);
        chk("x_reach", 32'(cx[i]), 32'(val));
    endtask

    task automatic wait_busy(input int i, input int budget);
        for (int k = 0; k < budget && !bz[i]; k++) @(negedge clk);
        chk("busy_seen", 32'(bz[i]), 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            dn[i] = 4'b1111; pd[i] = 1'b0; cl[i] = 1'b0; ci[i] = 3'd0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cur_x", 32'(cx[0]), 0);
        chk("rst_cur_y", 32'(cy[0]), 0);
        chk("rst_x", 32'(xo[0]), 0);
        chk("rst_y", 32'(yo[0]), 0);
        chk("rst_colour", 32'(co[0]), 0);
        chk("rst_plot", 32'(pl[0]), 0);
        chk("rst_busy", 32'(bz[0]), 0);
        dn[0] = 4'b1110;
        rst = 1'b0;

        // Right key: one step per 4 clocks, no plotting
        repeat (3) @(negedge clk);
        chk("step_x0", 32'(cx[0]), 0);
        @(negedge clk);
        chk("step_x1", 32'(cx[0]), 1);
        chk("step_plot1", 32'(pl[0]), 0);
        repeat (4) @(negedge clk);
        chk("step_x2", 32'(cx[0]), 2);
        repeat (4) @(negedge clk);
        chk("step_x3", 32'(cx[0]), 3);
        chk("step_plot3", 32'(pl[0]), 0);
        chk("step_y", 32'(cy[0]), 0);
        dn[0] = 4'b1111;

        // Clamp at the low edges (left + up held well past reaching 0)
        dn[0] = 4'b0011;
        repeat (32) @(negedge clk);
        chk("clamp_x", 32'(cx[0]), 0);
        chk("clamp_y", 32'(cy[0]), 0);
        dn[0] = 4'b1111;

        // Wrap: left from 0, up from 0, right from X_MAX
        dn[1] = 4'b0111;
        wait_x_ne(1, 8'd0, 12);
        dn[1] = 4'b1111;
        chk("wrap_left", 32'(cx[1]), 159);
        dn[1] = 4'b1011;
        wait_y_ne(1, 7'd0, 12);
        dn[1] = 4'b1111;
        chk("wrap_up", 32'(cy[1]), 119);
        dn[1] = 4'b1110;
        wait_x_ne(1, 8'd159, 12);
        dn[1] = 4'b1111;
        chk("wrap_right", 32'(cx[1]), 0);

        // Brush at the bottom-right corner: edge pixels suppressed
        dn[0] = 4'b1100;
        wait_x_eq(0, 8'd158, 1000);
        dn[0] = 4'b1111;
        chk("corner_y", 32'(cy[0]), 119);
        pd[0] = 1'b1;
        ci[0] = 3'b101;
        wait_busy(0, 12);
        pd[0] = 1'b0;
        ci[0] = 3'b000;
        chk("brush0_x", 32'(xo[0]), 158);
        chk("brush0_y", 32'(yo[0]), 119);
        chk("brush0_plot", 32'(pl[0]), 1);
        chk("brush0_col", 32'(co[0]), 5);
        @(negedge clk);
        chk("brush1_x", 32'(xo[0]), 159);
        chk("brush1_y", 32'(yo[0]), 119);
        chk("brush1_plot", 32'(pl[0]), 1);
        chk("brush1_col", 32'(co[0]), 5);
        @(negedge clk);
        chk("brush2_x", 32'(xo[0]), 158);
        chk("brush2_y", 32'(yo[0]), 120);
        chk("brush2_plot", 32'(pl[0]), 0);
        chk("brush2_busy", 32'(bz[0]), 1);
        @(negedge clk);
        chk("brush3_x", 32'(xo[0]), 159);
        chk("brush3_y", 32'(yo[0]), 120);
        chk("brush3_plot", 32'(pl[0]), 0);
        chk("brush3_col", 32'(co[0]), 5);
        @(negedge clk);
        chk("brush_end_busy", 32'(bz[0]), 0);
        chk("brush_end_plot", 32'(pl[0]), 0);

        // Reset during DRAW cycle 2
        pd[0] = 1'b1;
        wait_busy(0, 12);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pd[0] = 1'b0;
        chk("mid_rst_plot", 32'(pl[0]), 0);
        chk("mid_rst_busy", 32'(bz[0]), 0);
        chk("mid_rst_x", 32'(cx[0]), 0);
        chk("mid_rst_y", 32'(cy[0]), 0);

        // Ticks during a long DRAW collapse into one pending move
        do_reset();
        pd[2] = 1'b1;
        dn[2] = 4'b1110;
        wait_busy(2, 10);
        chk("pend_first_x", 32'(cx[2]), 1);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("pend_draw_busy", 32'(bz[2]), 1);
        end
        @(negedge clk);
        chk("pend_gap_busy", 32'(bz[2]), 0);
        chk("pend_gap_plot", 32'(pl[2]), 0);
        chk("pend_gap_x", 32'(cx[2]), 1);
        @(negedge clk);
        chk("pend_served_busy", 32'(bz[2]), 1);
        chk("pend_served_x", 32'(cx[2]), 2);
        pd[2] = 1'b0;
        dn[2] = 4'b1111;
        repeat (40) @(negedge clk);
        chk("pend_drop_x", 32'(cx[2]), 2);
        chk("pend_drop_busy", 32'(bz[2]), 0);

`ifdef CURSOR_CLEAR_EN
        // Clear request wins over a coincident tick; the move follows the sweep
        do_reset();
        repeat (3) @(negedge clk);
        cl[3] = 1'b1;
        dn[3] = 4'b1110;
        ci[3] = 3'd7;
        @(negedge clk);
        cl[3] = 1'b0;
        chk("clr_busy", 32'(bz[3]), 1);
        chk("clr_cur_x", 32'(cx[3]), 0);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            chk("clr_x", 32'(xo[3]), 32'(k % 4));
            chk("clr_y", 32'(yo[3]), 32'(k / 4));
            chk("clr_plot", 32'(pl[3]), 1);
            chk("clr_col", 32'(co[3]), 0);
        end
        @(negedge clk);
        chk("clr_end_busy", 32'(bz[3]), 0);
        chk("clr_end_plot", 32'(pl[3]), 0);
        chk("clr_end_x", 32'(cx[3]), 0);
        @(negedge clk);
        chk("clr_pend_x", 32'(cx[3]), 1);
        dn[3] = 4'b1111;
`else
        // Without the clear feature clear_req has no effect
        do_reset();
        cl[3] = 1'b1;
        dn[3] = 4'b1110;
        repeat (4) @(negedge clk);
        chk("noclr_busy", 32'(bz[3]), 0);
        chk("noclr_plot", 32'(pl[3]), 0);
        chk("noclr_x", 32'(cx[3]), 1);
        cl[3] = 1'b0;
        dn[3] = 4'b1111;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
